// File: rtl/dff_bank_arbiter.sv
// Round-robin two-master arbiter that sequences LOAD/SET/CLEAR strobes onto a DFF bank.
// Optional read-back checking of the bank is enabled by defining DFF_BANK_READBACK_EN.
module dff_bank_arbiter #(
    parameter int W       = 8,
    parameter int PULSE_W = 2
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         REQ0,
    input  logic         REQ1,
    input  logic [1:0]   CMD0,
    input  logic [1:0]   CMD1,
    input  logic [W-1:0] DIN0,
    input  logic [W-1:0] DIN1,
    input  logic [W-1:0] REG_Q,
    output logic         ACK0,
    output logic         ACK1,
    output logic         GNT,
    output logic         BUSY,
    output logic [W-1:0] REG_D,
    output logic         REG_LD,
    output logic         REG_PRE,
    output logic         REG_CLR,
    output logic         ERR
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_SETTLE, ST_DONE} state_t;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_LOAD  = 2'b01;
    localparam logic [1:0] CMD_SET   = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;
    localparam logic [3:0] CNT_INIT  = 4'(PULSE_W - 1);

    state_t       state_q, state_d;
    logic [1:0]   cmd_q, cmd_d;
    logic [W-1:0] din_q, din_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         last_q, last_d;
    logic         ack0_q, ack0_d, ack1_q, ack1_d;
    logic         gnt_q, gnt_d, busy_q, busy_d;
    logic [W-1:0] reg_d_q, reg_d_d;
    logic         reg_ld_q, reg_ld_d, reg_pre_q, reg_pre_d, reg_clr_q, reg_clr_d;
    logic         err_q, err_d;
    logic         sel;

`ifdef DFF_BANK_READBACK_EN
    logic [W-1:0] rb_exp;
    always_comb begin
        rb_exp = '0;
        if (cmd_q == CMD_LOAD)     rb_exp = din_q;
        else if (cmd_q == CMD_SET) rb_exp = '1;
    end
`else
    logic unused_reg_q;
    assign unused_reg_q = ^REG_Q;
`endif

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        din_d     = din_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        reg_d_d   = reg_d_q;
        err_d     = err_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        reg_ld_d  = 1'b0;
        reg_pre_d = 1'b1;
        reg_clr_d = 1'b1;
        // Tie goes to whoever was not served last; a lone request simply wins.
        sel       = (REQ0 && REQ1) ? ~last_q : REQ1;

        case (state_q)
            ST_IDLE: begin
                if (REQ0 || REQ1) begin
                    gnt_d = sel;
                    cmd_d = sel ? CMD1 : CMD0;
                    din_d = sel ? DIN1 : DIN0;
                    cnt_d = CNT_INIT;
                    case (cmd_d)
                        CMD_LOAD: begin
                            state_d  = ST_EXEC;
                            reg_ld_d = 1'b1;
                            reg_d_d  = din_d;
                        end
                        CMD_SET: begin
                            state_d   = ST_EXEC;
                            reg_pre_d = 1'b0;
                        end
                        CMD_CLEAR: begin
                            state_d   = ST_EXEC;
                            reg_clr_d = 1'b0;
                        end
                        default: begin
                            state_d = ST_DONE;
                            ack0_d  = ~sel;
                            ack1_d  = sel;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                if (cmd_q == CMD_LOAD || cmd_q == CMD_NOP || cnt_q == 4'd0) begin
                    state_d = ST_SETTLE;
                end else begin
                    cnt_d     = cnt_q - 4'd1;
                    reg_pre_d = (cmd_q != CMD_SET);
                    reg_clr_d = (cmd_q != CMD_CLEAR);
                end
            end
            ST_SETTLE: begin
                state_d = ST_DONE;
                ack0_d  = ~gnt_q;
                ack1_d  = gnt_q;
`ifdef DFF_BANK_READBACK_EN
                if (REG_Q != rb_exp) err_d = 1'b1;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                last_d  = gnt_q;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
`ifndef DFF_BANK_READBACK_EN
        err_d = 1'b0;
`endif
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q   <= ST_IDLE;
            cmd_q     <= CMD_NOP;
            din_q     <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            gnt_q     <= 1'b0;
            busy_q    <= 1'b0;
            reg_d_q   <= '0;
            reg_ld_q  <= 1'b0;
            reg_pre_q <= 1'b1;
            reg_clr_q <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            din_q     <= din_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            reg_d_q   <= reg_d_d;
            reg_ld_q  <= reg_ld_d;
            reg_pre_q <= reg_pre_d;
            reg_clr_q <= reg_clr_d;
            err_q     <= err_d;
        end
    end

    assign ACK0    = ack0_q;
    assign ACK1    = ack1_q;
    assign GNT     = gnt_q;
    assign BUSY    = busy_q;
    assign REG_D   = reg_d_q;
    assign REG_LD  = reg_ld_q;
    assign REG_PRE = reg_pre_q;
    assign REG_CLR = reg_clr_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter with a behavioural DFF bank model driving REG_Q.
module tb_dff_bank_arbiter;

`ifdef DFF_BANK_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic       CLK = 1'b0, CLR = 1'b0;
    logic       REQ0 = 1'b0, REQ1 = 1'b0;
    logic [1:0] CMD0 = 2'b00, CMD1 = 2'b00;
    logic [7:0] DIN0 = 8'h00, DIN1 = 8'h00;
    logic [7:0] REG_Q;
    logic       ACK0, ACK1, GNT, BUSY, REG_LD, REG_PRE, REG_CLR, ERR;
    logic [7:0] REG_D;

    logic [7:0] bank_q = 8'h00;
    logic       force_en = 1'b0;
    logic [7:0] force_val = 8'h00;

    int checks = 0, errors = 0;
    int ack_cyc, ack_cnt, oack_cnt, busy_cnt, gnt_bad, ld_cnt, ld_first;
    int pre_lo, pre_first, clr_lo, clr_first, viol, err_first;
    int nacks, overlap, gapbad, anyack;
    logic [7:0] ld_data;
    logic [3:0] order;
    logic       busy_after, prev_ack;

    dff_bank_arbiter #(.W(8), .PULSE_W(2)) dut (
        .CLK(CLK), .CLR(CLR), .REQ0(REQ0), .REQ1(REQ1), .CMD0(CMD0), .CMD1(CMD1),
        .DIN0(DIN0), .DIN1(DIN1), .REG_Q(REG_Q), .ACK0(ACK0), .ACK1(ACK1), .GNT(GNT),
        .BUSY(BUSY), .REG_D(REG_D), .REG_LD(REG_LD), .REG_PRE(REG_PRE),
        .REG_CLR(REG_CLR), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge REG_PRE or negedge REG_CLR) begin
        if (!REG_CLR)     bank_q <= 8'h00;
        else if (!REG_PRE) bank_q <= 8'hFF;
        else if (REG_LD)  bank_q <= REG_D;
    end
    assign REG_Q = force_en ? force_val : bank_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command from master m and gather per-cycle statistics until one cycle past ACK.
    task automatic issue(input int m, input logic [1:0] cmd, input logic [7:0] din);
        ack_cyc = 0; ack_cnt = 0; oack_cnt = 0; busy_cnt = 0; gnt_bad = 0;
        ld_cnt = 0; ld_first = 0; pre_lo = 0; pre_first = 0; clr_lo = 0; clr_first = 0;
        viol = 0; err_first = 0; ld_data = 8'h00; busy_after = 1'bx;
        @(negedge CLK);
        if (m == 0) begin REQ0 = 1'b1; CMD0 = cmd; DIN0 = din; end
        else        begin REQ1 = 1'b1; CMD1 = cmd; DIN1 = din; end
        for (int c = 1; c <= 15; c++) begin
            @(negedge CLK);
            if (BUSY) begin busy_cnt++; if (GNT !== m[0]) gnt_bad++; end
            if (REG_LD) begin ld_cnt++; if (ld_first == 0) ld_first = c; ld_data = REG_D; end
            if (!REG_PRE) begin pre_lo++; if (pre_first == 0) pre_first = c; end
            if (!REG_CLR) begin clr_lo++; if (clr_first == 0) clr_first = c; end
            if ((!REG_PRE && !REG_CLR) || (REG_LD && (!REG_PRE || !REG_CLR))) viol++;
            if (ERR && err_first == 0) err_first = c;
            if ((m == 0) ? ACK1 : ACK0) oack_cnt++;
            if ((m == 0) ? ACK0 : ACK1) begin
                ack_cnt++;
                if (ack_cyc == 0) ack_cyc = c;
                REQ0 = 1'b0; REQ1 = 1'b0;
            end
            if (c == 1) begin CMD0 = 2'b00; CMD1 = 2'b00; DIN0 = ~din; DIN1 = ~din; end
            if (ack_cyc != 0 && c == ack_cyc + 1) begin busy_after = BUSY; break; end
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_ack0", ACK0, 0);    chk("rst_ack1", ACK1, 0);
        chk("rst_gnt", GNT, 0);      chk("rst_busy", BUSY, 0);
        chk("rst_regd", REG_D, 0);   chk("rst_ld", REG_LD, 0);
        chk("rst_pre", REG_PRE, 1);  chk("rst_clr", REG_CLR, 1);
        chk("rst_err", ERR, 0);
        @(negedge CLK); CLR = 1'b1;
        repeat (2) @(negedge CLK);

        issue(0, 2'b01, 8'hA5);
        chk("load_ack_cyc", ack_cyc, 3);   chk("load_ack_cnt", ack_cnt, 1);
        chk("load_ld_cnt", ld_cnt, 1);     chk("load_ld_first", ld_first, 1);
        chk("load_regd", ld_data, 8'hA5);  chk("load_busy_cnt", busy_cnt, 3);
        chk("load_busy_after", busy_after, 0);
        chk("load_gnt", gnt_bad, 0);       chk("load_other_ack", oack_cnt, 0);
        chk("load_pre", pre_lo, 0);        chk("load_clr", clr_lo, 0);
        chk("load_bank", REG_Q, 8'hA5);    chk("load_regd_hold", REG_D, 8'hA5);
        chk("load_err", err_first, 0);

        issue(1, 2'b10, 8'h00);
        chk("set_ack_cyc", ack_cyc, 4);    chk("set_pre_lo", pre_lo, 2);
        chk("set_pre_first", pre_first, 1); chk("set_clr_lo", clr_lo, 0);
        chk("set_ld", ld_cnt, 0);          chk("set_busy_cnt", busy_cnt, 4);
        chk("set_gnt", gnt_bad, 0);        chk("set_viol", viol, 0);
        chk("set_bank", REG_Q, 8'hFF);     chk("set_regd_hold", REG_D, 8'hA5);

        issue(0, 2'b11, 8'h00);
        chk("clr_ack_cyc", ack_cyc, 4);    chk("clr_clr_lo", clr_lo, 2);
        chk("clr_clr_first", clr_first, 1); chk("clr_pre_lo", pre_lo, 0);
        chk("clr_viol", viol, 0);          chk("clr_bank", REG_Q, 8'h00);

        // Last served was master 0; a tie must now go to master 1 first? No: run tie after a master-1 grant.
        issue(1, 2'b00, 8'h00);
        @(negedge CLK);
        REQ0 = 1'b1; REQ1 = 1'b1; CMD0 = 2'b01; CMD1 = 2'b01; DIN0 = 8'h11; DIN1 = 8'h22;
        order = 4'h0; nacks = 0; overlap = 0; gapbad = 0; prev_ack = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            if (prev_ack && BUSY) gapbad++;
            prev_ack = ACK0 | ACK1;
            if (ACK0 && ACK1) overlap++;
            if (ACK0)      begin order = {order[2:0], 1'b0}; nacks++; end
            else if (ACK1) begin order = {order[2:0], 1'b1}; nacks++; end
            if (nacks == 4) begin REQ0 = 1'b0; REQ1 = 1'b0; break; end
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        chk("tie_nacks", nacks, 4);   chk("tie_order", order, 4'b0101);
        chk("tie_overlap", overlap, 0); chk("tie_gap", gapbad, 0);
        @(negedge CLK);
        chk("tie_idle", BUSY, 0);

        // Leave master 0 as last served so only a reset can make master 0 win the next tie.
        issue(0, 2'b00, 8'h00);
        @(negedge CLK);
        REQ0 = 1'b1; CMD0 = 2'b11;
        @(negedge CLK);
        chk("abort_clr_low", REG_CLR, 0);
        #2 CLR = 1'b0;
        #1;
        chk("abort_clr_rel", REG_CLR, 1); chk("abort_busy", BUSY, 0);
        chk("abort_ack0", ACK0, 0);
        REQ0 = 1'b0; CMD0 = 2'b00;
        @(negedge CLK); CLR = 1'b1;
        anyack = 0;
        repeat (5) begin
            @(negedge CLK);
            if (ACK0 || ACK1 || !REG_CLR || BUSY) anyack++;
        end
        chk("abort_quiet", anyack, 0);

        REQ0 = 1'b1; REQ1 = 1'b1; CMD0 = 2'b00; CMD1 = 2'b00;
        @(negedge CLK);
        chk("rtie_ack0", ACK0, 1); chk("rtie_ack1", ACK1, 0); chk("rtie_gnt", GNT, 0);
        REQ0 = 1'b0;
        @(negedge CLK);
        chk("rtie_idle", BUSY, 0);
        @(negedge CLK);
        chk("rtie_ack1b", ACK1, 1); chk("rtie_gnt1", GNT, 1);
        REQ1 = 1'b0;
        @(negedge CLK);

        issue(1, 2'b00, 8'h00);
        chk("nop_ack_cyc", ack_cyc, 1);   chk("nop_busy_cnt", busy_cnt, 1);
        chk("nop_ld", ld_cnt, 0);         chk("nop_pre", pre_lo, 0);
        chk("nop_clr", clr_lo, 0);        chk("nop_other_ack", oack_cnt, 0);

        force_en = 1'b1; force_val = 8'h3D;
        issue(0, 2'b01, 8'h3C);
        force_en = 1'b0;
        chk("rb_bad_ack", ack_cyc, 3);
        chk("rb_bad_err_first", err_first, (RB != 0) ? 3 : 0);
        issue(0, 2'b01, 8'h55);
        chk("rb_good_err_first", err_first, (RB != 0) ? 1 : 0);
        chk("rb_good_bank", REG_Q, 8'h55);
        chk("rb_sticky", ERR, RB[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Two-requester arbiter and sequencer for a W-bit register bank built from D flip-flops with active-low asynchronous preset and clear. It accepts LOAD / SET / CLEAR / NOP commands from two masters over a req/ack handshake and grants them round-robin. It drives the bank's shared data, load-enable, preset and clear lines with correctly sequenced, glitch-free registered strobes. It sits between the control logic and the register bank, and is the only driver of the bank's PRE/CLR pins.

## Interface
- W, 8, register bank width in bits
- PULSE_W, 2, cycles REG_PRE / REG_CLR are held low for SET / CLEAR (legal range 1..15)

- CLK  in  1  system clock; rising edge active
- CLR  in  1  reset, asynchronous, active-low
- REQ0, REQ1  in  1  request from master 0 / master 1; level, held until the matching ACK
- CMD0, CMD1  in  2  command: 00 NOP, 01 LOAD, 10 SET (all ones), 11 CLEAR (all zeros)
- DIN0, DIN1  in  W  load data, used only for LOAD
- REG_Q  in  W  bank Q outputs (read back)
- ACK0, ACK1  out  1  one-cycle completion pulse to master 0 / master 1
- GNT  out  1  index of the master currently being served
- BUSY  out  1  high from grant until the ACK cycle inclusive
- REG_D  out  W  data to the bank D inputs
- REG_LD  out  1  bank load enable (one cycle)
- REG_PRE  out  1  bank preset, active-low
- REG_CLR  out  1  bank clear, active-low
- ERR  out  1  sticky read-back mismatch flag

## Operation
- All outputs are registered.
- Reset values are: ACK0=0, ACK1=0, GNT=0, BUSY=0, REG_D=0, REG_LD=0, REG_PRE=1, REG_CLR=1, ERR=0, last-grant pointer=1, state=IDLE.
- States and transitions:
  - IDLE: waits for a request; moves to EXEC when one is granted.
  - EXEC: performs the command.
  - SETTLE: waits one cycle for the bank to settle.
  - DONE: issues ACK.
- Arbitration in IDLE:
  - If only one REQ is high, that master is granted.
  - If both are high, the master other than the last-granted one wins. After reset, master 0 wins the first tie.
  - On grant, CMD, DIN and the master index are latched. Later changes to CMD/DIN are ignored.
- Command behaviour:
  - LOAD: in EXEC, REG_D = latched DIN and REG_LD = 1 for exactly one cycle. Then SETTLE, then DONE.
  - SET: REG_PRE = 0 for PULSE_W cycles (down-counter in EXEC), REG_LD = 0. Then SETTLE, then DONE.
  - CLEAR: same as SET, but on REG_CLR.
  - NOP: goes from IDLE directly to DONE. No bank activity.
- DONE: the ACK line of the granted master is 1 for one cycle. The last-grant pointer is updated, and the state returns to IDLE.
- REG_PRE and REG_CLR are never low in the same cycle.
- REG_LD is never high while either of them is low.
- REG_D holds its last value outside LOAD.
- A master that keeps REQ high after its ACK is re-arbitrated in the following IDLE cycle. If the other master is also requesting, the other master wins.
- Reset asserted mid-operation:
  - All outputs go to their reset values immediately (asynchronously).
  - An in-progress pulse is truncated.
  - No ACK is issued for the aborted command.

## Timing
- Counting the edge at which IDLE samples REQ as edge 0:
  - LOAD: REG_LD is high during cycle 1, SETTLE is cycle 2, ACK is high during cycle 3. Total 3 cycles; the next grant can occur at edge 4.
  - SET / CLEAR: strobe is low during cycles 1..PULSE_W, SETTLE is cycle PULSE_W+1, ACK is at cycle PULSE_W+2.
  - NOP: ACK is at cycle 1.
- BUSY rises at edge 0 and falls at the edge ending the ACK cycle.
- GNT is valid while BUSY is high.
- Between the end of an ACK cycle and the next grant there is at least one IDLE cycle.

## Configuration
- `DFF_BANK_READBACK_EN` defined:
  - In SETTLE, REG_Q is compared with the expected value: latched DIN for LOAD, all ones for SET, all zeros for CLEAR.
  - A mismatch sets ERR from the next cycle. ERR stays set until reset.
  - NOP performs no check.
- Undefined:
  - ERR is constant 0 and REG_Q is unused.
  - Timing is identical in both configurations.

## Test plan
- Reset, then REQ0 with LOAD and DIN0=8'hA5 → REG_LD high for exactly 1 cycle with REG_D=8'hA5, ACK0 pulse 3 cycles after grant, GNT=0.
- REQ1 with SET, PULSE_W=2 → REG_PRE low for exactly 2 cycles, REG_CLR held at 1, ACK1 at cycle 4.
- REQ0 and REQ1 both rise in the same cycle, then both are held high → grant order 0,1,0,1, with no overlapping ACKs.
- Reset pulsed in the middle of a CLEAR pulse → REG_CLR returns to 1 immediately, BUSY=0, no ACK is issued, and the next tie is won by master 0.
- With `DFF_BANK_READBACK_EN`, a LOAD of 8'h3C while REG_Q is forced to 8'h3D → ERR=1 from the cycle after SETTLE, still 1 after a subsequent good LOAD. With the macro undefined, ERR stays 0 throughout.
- REQ1 with NOP → ACK1 one cycle after grant, and REG_LD, REG_PRE and REG_CLR never toggle.
